// File: rtl/pio_pkg.sv
// Shared PIO shift-register definitions: direction codes, widths and count helpers.
package pio_pkg;

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned FLD_W = 5;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  // A 5-bit count field of zero encodes a full 32-bit word.
  function automatic logic [CNT_W-1:0] decode_count5(input logic [FLD_W-1:0] c);
    return (c == '0) ? CNT_W'(32) : CNT_W'(c);
  endfunction

  // Sum is formed one bit wider so 32+32 cannot wrap before saturating.
  function automatic logic [CNT_W-1:0] sat32_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = (CNT_W+1)'(a) + (CNT_W+1)'(b);
    return (s > (CNT_W+1)'(32)) ? CNT_W'(32) : CNT_W'(s);
  endfunction

endpackage

// File: rtl/isr_shift_merge.sv
// Combinational ISR merge: shifts n bits of data_in into isr from the selected side.
module isr_shift_merge
  import pio_pkg::*;
(
  input  logic [W-1:0]     isr,
  input  logic [W-1:0]     data_in,
  input  logic [CNT_W-1:0] n,
  input  logic             dir,
  output logic [W-1:0]     new_isr
);

  logic [W-1:0]       mask;
  logic [W-1:0]       bits;
  logic [FLD_W-1:0]   sh;
  logic [FLD_W-1:0]   up;

  // n is 1..32; the 32 case is handled separately so 5-bit shift amounts never overflow.
  always_comb begin
    sh      = n[FLD_W-1:0];
    up      = FLD_W'(CNT_W'(32) - n);
    mask    = (W'(1) << sh) - W'(1);
    bits    = data_in & mask;
    new_isr = '0;
    if (n == CNT_W'(32)) begin
      new_isr = data_in;
    end else if (dir == SHIFT_RIGHT) begin
      new_isr = (isr >> sh) | (bits << up);
    end else begin
      new_isr = (isr << sh) | bits;
    end
  end

endmodule

// File: rtl/input_shift_register.sv
// PIO input shift register: IN accumulation, PUSH variants and MOV to/from ISR.
// Autopush is built only when ISR_AUTOPUSH_EN is defined; otherwise the autopush input is ignored.
module input_shift_register
  import pio_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     data_in,
  input  logic             shift_en,
  input  logic [FLD_W-1:0] shift_count,
  input  logic             shiftdir,
  input  logic             autopush,
  input  logic [FLD_W-1:0] push_thresh,
  input  logic             push_en,
  input  logic             push_iffull,
  input  logic             push_block,
  input  logic             fifo_full,
  output logic [W-1:0]     fifo_out,
  output logic             fifo_push,
  input  logic [W-1:0]     mov_in,
  input  logic [1:0]       mov,
  output logic [W-1:0]     mov_out,
  output logic             stall,
  output logic [CNT_W-1:0] input_shift_counter
);

  logic [W-1:0]     isr_q, isr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     mov_out_q, mov_out_d;

  logic [CNT_W-1:0] n_c;
  logic [CNT_W-1:0] thr_c;
  logic [CNT_W-1:0] cnt_new_c;
  logic [W-1:0]     merged_c;
  logic             ap_full_c;
  logic             ap_new_c;
  logic             fifo_push_c;
  logic [W-1:0]     fifo_out_c;
  logic             stall_c;

  assign n_c       = decode_count5(shift_count);
  assign thr_c     = decode_count5(push_thresh);
  assign cnt_new_c = sat32_add(cnt_q, n_c);

  isr_shift_merge u_merge (
    .isr     (isr_q),
    .data_in (data_in),
    .n       (n_c),
    .dir     (shiftdir),
    .new_isr (merged_c)
  );

`ifdef ISR_AUTOPUSH_EN
  assign ap_full_c = autopush && (cnt_q >= thr_c);
  assign ap_new_c  = autopush && (cnt_new_c >= thr_c);
`else
  logic unused_autopush;
  assign unused_autopush = autopush;
  assign ap_full_c       = 1'b0;
  assign ap_new_c        = 1'b0;
`endif

  // Priority decode; combinational strobes are forced low while reset is asserted.
  always_comb begin
    isr_d       = isr_q;
    cnt_d       = cnt_q;
    mov_out_d   = mov_out_q;
    fifo_push_c = 1'b0;
    fifo_out_c  = '0;
    stall_c     = 1'b0;
    if (!rst) begin
      if (mov[0]) begin
        isr_d = mov_in;
        cnt_d = '0;
      end else if (mov[1]) begin
        mov_out_d = isr_q;
      end else if (push_en) begin
        if (push_iffull && (cnt_q < thr_c)) begin
          stall_c = 1'b0;
        end else if (fifo_full && push_block) begin
          stall_c = 1'b1;
        end else begin
          fifo_push_c = !fifo_full;
          fifo_out_c  = fifo_full ? '0 : isr_q;
          isr_d       = '0;
          cnt_d       = '0;
        end
      end else if (shift_en) begin
        if (ap_full_c) begin
          // Drain a full ISR first; the IN itself retires on a later cycle.
          stall_c = 1'b1;
          if (!fifo_full) begin
            fifo_push_c = 1'b1;
            fifo_out_c  = isr_q;
            isr_d       = '0;
            cnt_d       = '0;
          end
        end else if (ap_new_c && !fifo_full) begin
          fifo_push_c = 1'b1;
          fifo_out_c  = merged_c;
          isr_d       = '0;
          cnt_d       = '0;
        end else begin
          isr_d = merged_c;
          cnt_d = cnt_new_c;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      isr_q     <= '0;
      cnt_q     <= '0;
      mov_out_q <= '0;
    end else begin
      isr_q     <= isr_d;
      cnt_q     <= cnt_d;
      mov_out_q <= mov_out_d;
    end
  end

  assign fifo_push           = fifo_push_c;
  assign fifo_out            = fifo_out_c;
  assign stall               = stall_c;
  assign mov_out             = mov_out_q;
  assign input_shift_counter = cnt_q;

endmodule
